// File: rtl/aes_word_loader.sv
// aes_word_loader
//   Gathers a 128-bit key and a 128-bit text block from a 32-bit stream
//   (most significant word first), launches an AES core and streams the
//   128-bit result back out as four 32-bit words.
//   For decrypt jobs the core's key expansion (core_kld/core_kdone) runs
//   before the core start (core_ld).
//   Waits on the core are bounded by TIMEOUT cycles. On expiry err pulses,
//   the job is dropped and no result is produced.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   mode            0 = encrypt, 1 = decrypt; taken from word 0 of a job
//   in_valid/in_ready/in_data     input word stream (8 words per job)
//   out_valid/out_ready/out_data  result word stream (4 words per job)
//   err             one-cycle pulse when the core times out
//   core_mode/core_key/core_text  job parameters to the core
//   core_ld/core_kld              one-cycle start / key-expansion pulses
//   core_done/core_kdone          core completion strobes
//   core_text_out                 core result
module aes_word_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         err,
  output logic         core_mode,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  output logic         core_ld,
  output logic         core_kld,
  input  logic         core_done,
  input  logic         core_kdone,
  input  logic [127:0] core_text_out
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_KLD, S_KWAIT, S_LOAD, S_BUSY, S_DRAIN
  } state_t;

  state_t         r_state, w_next;
  logic           r_alive;      // low only until the first edge after reset
  logic [2:0]     r_wcnt;       // input word index, wraps after word 7
  logic [1:0]     r_ocnt;       // output word index
  logic [TW-1:0]  r_tcnt;       // cycles spent waiting on the core
  logic [127:0]   r_key, r_text, r_result;
  logic           r_mode, r_err;
  logic           w_accepting, w_in_xfer, w_out_xfer, w_tmo, w_err_set;

  // in_ready is gated by r_alive so it stays low through reset and rises
  // on the first edge after reset releases.
  assign w_accepting = r_alive && (r_state == S_IDLE || r_state == S_COLLECT);
  assign w_in_xfer   = in_valid && w_accepting;
  assign w_out_xfer  = (r_state == S_DRAIN) && out_ready;
  // Counter restarts at 0 on wait entry, so hitting TIMEOUT-1 means the
  // current cycle is the TIMEOUT-th cycle of the wait.
  assign w_tmo       = (r_tcnt == TW'(TIMEOUT - 1));

  assign in_ready  = w_accepting;
  assign out_valid = (r_state == S_DRAIN);
  assign core_ld   = (r_state == S_LOAD);
  assign core_kld  = (r_state == S_KLD);
  assign core_mode = r_mode;
  assign core_key  = r_key;
  assign core_text = r_text;
  assign err       = r_err;

  always_comb begin
    out_data = r_result[127:96];
    case (r_ocnt)
      2'd1:    out_data = r_result[95:64];
      2'd2:    out_data = r_result[63:32];
      2'd3:    out_data = r_result[31:0];
      default: out_data = r_result[127:96];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE:    if (w_in_xfer) w_next = S_COLLECT;
      S_COLLECT: if (w_in_xfer && r_wcnt == 3'd7) w_next = r_mode ? S_KLD : S_LOAD;
      S_KLD:     w_next = S_KWAIT;
      S_KWAIT: begin
        if (core_kdone) w_next = S_LOAD;
        else if (w_tmo) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_LOAD:    w_next = S_BUSY;
      S_BUSY: begin
        if (core_done) w_next = S_DRAIN;
        else if (w_tmo) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_DRAIN:   if (w_out_xfer && r_ocnt == 2'd3) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alive  <= 1'b0;
      r_err    <= 1'b0;
      r_mode   <= 1'b0;
      r_wcnt   <= '0;
      r_ocnt   <= '0;
      r_tcnt   <= '0;
      r_key    <= '0;
      r_text   <= '0;
      r_result <= '0;
    end else begin
      r_alive <= 1'b1;
      r_err   <= w_err_set;

      if (w_in_xfer) begin
        if (r_state == S_IDLE) r_mode <= mode;
        r_wcnt <= r_wcnt + 3'd1;
        for (int i = 0; i < 4; i++) begin
          if (r_wcnt == 3'(i))     r_key[127-32*i -: 32]  <= in_data;
          if (r_wcnt == 3'(i + 4)) r_text[127-32*i -: 32] <= in_data;
        end
      end

      if (r_state == S_KWAIT || r_state == S_BUSY) r_tcnt <= r_tcnt + 1'b1;
      else                                         r_tcnt <= '0;

      if (r_state == S_BUSY && core_done) r_result <= core_text_out;

      if (w_out_xfer) r_ocnt <= r_ocnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_aes_word_loader.sv
module tb_aes_word_loader;
  localparam int T = 20;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic core_done = 1'b0, core_kdone = 1'b0;
  logic [31:0]  in_data = '0;
  logic [127:0] core_text_out = '0;
  logic in_ready, out_valid, err, core_mode, core_ld, core_kld;
  logic [31:0]  out_data;
  logic [127:0] core_key, core_text;

  aes_word_loader #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .core_mode(core_mode), .core_key(core_key), .core_text(core_text),
    .core_ld(core_ld), .core_kld(core_kld), .core_done(core_done), .core_kdone(core_kdone),
    .core_text_out(core_text_out));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [31:0]  sbq[$];     // expected result words
  logic [256:0] ldq[$];     // expected {mode,key,text} at core_ld
  int exp_err = 0, jobs_issued = 0, jobs_done = 0;
  bit stub_hang = 0, bp = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in AES core: known FIPS-197 vectors, otherwise an arbitrary mix.
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k, input logic [127:0] t);
    if (!m && k == K0 && t == P0) return C0;
    if (m && k == K0 && t == C0)  return P0;
    return m ? (t ^ ~k) : ({t[63:0], t[127:64]} ^ k);
  endfunction

  // Core model with random latency and spurious strobes outside the wait states.
  initial begin
    int done_at = -1, kd_at = -1;
    bit busy = 0, kw = 0;
    logic [127:0] res = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 0; core_kdone = 0;
      core_text_out = {$urandom, $urandom, $urandom, $urandom};
      if (!rst) begin
        done_at = -1; kd_at = -1; busy = 0; kw = 0;
      end else begin
        if (done_at == cyc) begin
          core_done = 1; core_text_out = res; done_at = -1; busy = 0;
        end else if (!busy && $urandom_range(0, 7) == 0) core_done = 1;
        if (kd_at == cyc) begin
          core_kdone = 1; kd_at = -1; kw = 0;
        end else if (!kw && $urandom_range(0, 7) == 0) core_kdone = 1;
        if (err) begin busy = 0; kw = 0; end
        if (core_ld) begin
          busy = 1;
          res = core_fn(core_mode, core_key, core_text);
          if (!stub_hang) done_at = cyc + int'($urandom_range(1, 8));
        end
        if (core_kld) begin
          kw = 1; kd_at = cyc + int'($urandom_range(1, 8));
        end
      end
    end
  end

  // Downstream ready: random, or held low 5 cycles per word when bp is set.
  initial begin
    int st = 0;
    forever begin
      @(posedge clk); #1;
      if (!bp) out_ready = ($urandom_range(0, 3) != 0);
      else if (out_ready) begin out_ready = 0; st = 0; end
      else if (out_valid) begin st++; if (st >= 5) out_ready = 1; end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [31:0]  pd = '0;
    logic [256:0] e;
    logic [127:0] lk = '0, lt = '0;
    bit pstall = 0, perr = 0, kwm = 0;
    int wcount = 0, ocount = 0, w7 = -100, kdc = -100, ldc = -100, nkld = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pstall = 0; perr = 0; wcount = 0; ocount = 0; nkld = 0; kwm = 0;
        continue;
      end
      if (pstall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
      end
      pstall = out_valid && !out_ready;
      pd = out_data;
      if (in_valid && in_ready) begin
        if (wcount == 7) begin w7 = cyc; nkld = 0; end
        wcount = (wcount + 1) % 8;
      end
      if (core_kdone && kwm) begin kdc = cyc; kwm = 0; end
      if (core_kld) begin
        nkld++; kwm = 1;
        chk("kld_latency", cyc - w7, 1);
      end
      if (core_ld) begin
        ldc = cyc;
        chk("ld_expected", ldq.size() != 0, 1);
        if (ldq.size() != 0) begin
          e = ldq.pop_front();
          chk("core_mode", core_mode, e[256]);
          chk("core_key", core_key, e[255:128]);
          chk("core_text", core_text, e[127:0]);
          chk("kld_count", nkld, e[256]);
          if (e[256]) chk("ld_after_kdone", cyc - kdc, 1);
          else        chk("ld_latency", cyc - w7, 1);
          lk = core_key; lt = core_text;
        end
      end
      if (err) begin
        chk("err_single", perr, 0);
        chk("err_expected", exp_err > 0, 1);
        chk("err_timing", cyc - ldc, T + 1);
        chk("err_no_output", sbq.size(), 0);
        if (exp_err > 0) exp_err--;
        jobs_done++;
      end
      perr = err;
      if (out_valid) begin
        chk("valid_expected", sbq.size() != 0, 1);
        if (out_ready && sbq.size() != 0) begin
          chk("out_data", out_data, sbq.pop_front());
          chk("key_hold", core_key, lk);
          chk("text_hold", core_text, lt);
          ocount++;
          if (ocount == 4) begin ocount = 0; jobs_done++; end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic md);
    int g = 0;
    while ($urandom_range(0, 2) == 0) begin
      in_valid = 0; in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1; in_data = d; mode = md;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      g++;
      if (g > 300) begin chk("in_accept_timeout", g, 0); break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_job(input logic m, input logic [127:0] k, input logic [127:0] t,
                          input bit hang, input bit ovr, input logic [127:0] ovr_res, input bit flip);
    logic [127:0] r;
    int g = 0;
    stub_hang = hang;
    for (int i = 0; i < 8; i++) begin
      logic md;
      md = (i == 0 || !flip) ? m : 1'($urandom_range(0, 1));
      send_word(i < 4 ? k[127-32*i -: 32] : t[127-32*(i-4) -: 32], md);
    end
    if (flip) mode = ~m;
    r = ovr ? ovr_res : core_fn(m, k, t);
    ldq.push_back({m, k, t});
    jobs_issued++;
    if (hang) exp_err++;
    else for (int j = 0; j < 4; j++) sbq.push_back(r[127-32*j -: 32]);
    while (jobs_done < jobs_issued && g < 1000) begin @(posedge clk); #1; g++; end
    chk("job_complete", jobs_done, jobs_issued);
    stub_hang = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_core_ld", core_ld, 0);
    chk("rst_core_kld", core_kld, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_text", core_text, 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_edge", in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] k, t;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    release_reset();

    send_job(0, K0, P0, 0, 1, C0, 0);
    send_job(1, K0, C0, 0, 1, P0, 0);

    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      t = {$urandom, $urandom, $urandom, $urandom};
      send_job(1'($urandom_range(0, 1)), k, t, 0, 0, '0, 1);
    end

    bp = 1;
    for (int n = 0; n < 2; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      t = {$urandom, $urandom, $urandom, $urandom};
      send_job(1'(n), k, t, 0, 0, '0, 0);
    end
    bp = 0;

    k = {$urandom, $urandom, $urandom, $urandom};
    t = {$urandom, $urandom, $urandom, $urandom};
    send_job(0, k, t, 1, 0, '0, 0);
    send_job(0, K0, P0, 0, 1, C0, 0);

    // Abandon a decrypt job after word 5.
    for (int i = 0; i < 6; i++) send_word($urandom, 1'b1);
    rst = 0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    release_reset();
    send_job(1, K0, C0, 0, 1, P0, 1);

    repeat (5) @(posedge clk);
    chk("queues_drained", sbq.size() + ldq.size() + exp_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
